// File: rtl/onewire_pkg.sv
// Command codes, FSM state encoding and default bus timing for the 1-Wire master.
// Durations are in microseconds of the local timebase.
package onewire_pkg;

    typedef enum logic [1:0] {
        CMD_BUS_RESET  = 2'd0,
        CMD_WRITE_BYTE = 2'd1,
        CMD_READ_BYTE  = 2'd2,
        CMD_NOP        = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_LOW   = 3'd1,
        ST_RST_WAIT  = 3'd2,
        ST_SLOT_LOW  = 3'd3,
        ST_SLOT_HIGH = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    localparam int unsigned US_W               = 10;
    localparam int unsigned DEF_TICK_DIV       = 29;
    localparam int unsigned DEF_RESET_LOW_US   = 480;
    localparam int unsigned DEF_PRESENCE_US    = 70;
    localparam int unsigned DEF_RESET_TOTAL_US = 480;
    localparam int unsigned DEF_SLOT_US        = 70;
    localparam int unsigned DEF_WRITE0_LOW_US  = 60;
    localparam int unsigned DEF_SHORT_LOW_US   = 6;
    localparam int unsigned DEF_SAMPLE_US      = 15;

    function automatic logic [US_W-1:0] us_cnt(input int unsigned n);
        return US_W'(n);
    endfunction

endpackage

// File: rtl/onewire_if.sv
// Host command/response channel: valid/ready command in, one-cycle response strobe out.
// The block never stalls a response; the host must take rsp_data when rsp_valid is high.
interface onewire_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;

    modport master (
        output cmd_valid, cmd, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/onewire_timebase.sv
// Free-running microsecond prescaler plus a per-state microsecond counter.
// Zero latency on us_tick; clear wins over tick; no backpressure.
module onewire_timebase #(
    parameter int unsigned TICK_DIV = 29
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       clear,
    output logic       us_tick,
    output logic [9:0] us_count
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [9:0]    us_count_q;

    assign us_tick  = (presc_q == PW'(TICK_DIV - 1));
    assign us_count = us_count_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            presc_q    <= '0;
            us_count_q <= '0;
        end else begin
            presc_q <= us_tick ? '0 : presc_q + 1'b1;
            if (clear) begin
                us_count_q <= '0;
            end else if (us_tick) begin
                us_count_q <= us_count_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/onewire_master.sv
// Byte-level 1-Wire master driving an open-drain pad; one command at a time, ~960 us reset, ~560 us byte.
// cmd_ready is low from accept until the cycle after the response strobe; commands are never queued.
module onewire_master
    import onewire_pkg::*;
#(
    parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
    parameter int unsigned RESET_LOW_US   = DEF_RESET_LOW_US,
    parameter int unsigned PRESENCE_US    = DEF_PRESENCE_US,
    parameter int unsigned RESET_TOTAL_US = DEF_RESET_TOTAL_US,
    parameter int unsigned SLOT_US        = DEF_SLOT_US,
    parameter int unsigned WRITE0_LOW_US  = DEF_WRITE0_LOW_US,
    parameter int unsigned SHORT_LOW_US   = DEF_SHORT_LOW_US,
    parameter int unsigned SAMPLE_US      = DEF_SAMPLE_US
) (
    input  logic      clk,
    input  logic      nReset,
    onewire_if.slave  bus,
    output logic      pad_drive_n,
    input  logic      pad_in
);
    localparam logic [9:0] N_RST_LOW   = us_cnt(RESET_LOW_US);
    localparam logic [9:0] N_PRES_M1   = us_cnt(PRESENCE_US - 1);
    localparam logic [9:0] N_RST_TOTAL = us_cnt(RESET_TOTAL_US);
    localparam logic [9:0] N_SLOT      = us_cnt(SLOT_US);
    localparam logic [9:0] N_WRITE0    = us_cnt(WRITE0_LOW_US);
    localparam logic [9:0] N_SHORT     = us_cnt(SHORT_LOW_US);
    // SLOT_HIGH restarts the counter, so the read sample is offset by the short low time.
    localparam logic [9:0] N_SAMPLE_M1 = us_cnt(SAMPLE_US - SHORT_LOW_US - 1);

    state_e     state_q, state_d;
    cmd_e       cmd_q, cmd_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       presence_q, presence_d;
    logic       short_q, short_d;
    logic       rd_bit_q, rd_bit_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       busy_q, busy_d;
    logic       pad_drive_n_q, pad_drive_n_d;
    logic       sync1_q, sync2_q;

    logic       us_tick;
    logic [9:0] us_count;
    logic       tb_clear;
    logic       accept;
    logic [9:0] slot_low_len;
    logic [9:0] slot_high_len;

    onewire_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
        .clk      (clk),
        .nReset   (nReset),
        .clear    (tb_clear),
        .us_tick  (us_tick),
        .us_count (us_count)
    );

    assign accept        = cmd_ready_q && bus.cmd_valid;
    assign slot_low_len  = (cmd_q == CMD_WRITE_BYTE && !sr_q[0]) ? N_WRITE0 : N_SHORT;
    assign slot_high_len = N_SLOT - slot_low_len;
    assign tb_clear      = (state_d != state_q);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        presence_d = presence_q;
        short_d    = short_q;
        rd_bit_d   = rd_bit_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d = cmd_e'(bus.cmd);
                    case (cmd_e'(bus.cmd))
                        CMD_BUS_RESET:  state_d = ST_RST_LOW;
                        CMD_WRITE_BYTE: begin
                            sr_d      = bus.cmd_data;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_SLOT_LOW;
                        end
                        CMD_READ_BYTE: begin
                            sr_d      = 8'hFF;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_SLOT_LOW;
                        end
                        default:        state_d = ST_DONE;
                    endcase
                end
            end
            ST_RST_LOW: begin
                if (us_count >= N_RST_LOW) state_d = ST_RST_WAIT;
            end
            ST_RST_WAIT: begin
                if (us_tick && us_count == N_PRES_M1) presence_d = ~sync2_q;
                if (us_count >= N_RST_TOTAL) begin
                    short_d = ~sync2_q;
                    state_d = ST_DONE;
                end
            end
            ST_SLOT_LOW: begin
                if (us_count >= slot_low_len) state_d = ST_SLOT_HIGH;
            end
            ST_SLOT_HIGH: begin
                if (us_tick && us_count == N_SAMPLE_M1) rd_bit_d = sync2_q;
                if (us_count >= slot_high_len) begin
                    sr_d      = {(cmd_q == CMD_READ_BYTE) ? rd_bit_q : 1'b1, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == 3'd7) ? ST_DONE : ST_SLOT_LOW;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                case (cmd_q)
                    CMD_BUS_RESET: rsp_data_d = {6'b0, short_q, presence_q};
                    CMD_READ_BYTE: rsp_data_d = sr_q;
                    default:       rsp_data_d = 8'h00;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        rsp_valid_d   = (state_q == ST_DONE);
        cmd_ready_d   = (state_d == ST_IDLE) && !rsp_valid_d;
        busy_d        = (state_d != ST_IDLE);
        pad_drive_n_d = !(state_d == ST_RST_LOW || state_d == ST_SLOT_LOW);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q       <= ST_IDLE;
            cmd_q         <= CMD_NOP;
            sr_q          <= 8'h00;
            bit_cnt_q     <= 3'd0;
            presence_q    <= 1'b0;
            short_q       <= 1'b0;
            rd_bit_q      <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            pad_drive_n_q <= 1'b1;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            presence_q    <= presence_d;
            short_q       <= short_d;
            rd_bit_q      <= rd_bit_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            pad_drive_n_q <= pad_drive_n_d;
            sync1_q       <= pad_in;
            sync2_q       <= sync1_q;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;
    assign pad_drive_n   = pad_drive_n_q;
endmodule

// File: tb/tb_onewire_master.sv
// Randomised bench for onewire_master with a wire-level device model and a response scoreboard.
// Times are measured in clock cycles; one local microsecond is T cycles.
module tb_onewire_master;
    localparam int T = 4;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic pad_drive_n;
    logic pad_in;
    logic dev_low = 1'b0;

    onewire_if bus();

    assign pad_in = pad_drive_n & ~dev_low;

    onewire_master #(.TICK_DIV(T)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .bus         (bus),
        .pad_drive_n (pad_drive_n),
        .pad_in      (pad_in)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Device model: 0 = absent, 1 = answers resets with presence, 2 = bus shorted low.
    int         dev_mode = 0;
    bit         rd_mode = 0;
    logic [7:0] rd_byte = 8'h00;
    int         rd_idx = 0;
    longint     pw_q[$];
    longint     st_q[$];

    initial begin : device
        forever begin : slot
            longint t0;
            longint w;
            bit     drv0;
            @(negedge pad_drive_n);
            t0   = cyc;
            drv0 = 1'b0;
            if (rd_mode && rd_idx < 8) begin
                drv0 = !rd_byte[rd_idx];
                rd_idx++;
                if (drv0) dev_low = 1'b1;
            end
            @(posedge pad_drive_n);
            w = cyc - t0;
            pw_q.push_back(w);
            st_q.push_back(t0);
            if (drv0) begin
                while (cyc < t0 + 30 * T) @(posedge clk);
                dev_low = 1'b0;
            end
            if (w > 300 * T && dev_mode == 1) begin
                repeat (15 * T) @(posedge clk);
                dev_low = 1'b1;
                repeat (120 * T) @(posedge clk);
                dev_low = 1'b0;
            end
        end
    end

    // Scoreboard: every response strobe must match the oldest outstanding expectation.
    logic [7:0] exp_q[$];
    int         rsp_cnt = 0;
    longint     rsp_cyc = 0;

    always @(negedge clk) begin
        if (nReset) begin
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_data %0h with nothing outstanding", bus.rsp_data);
                end else begin
                    chk("rsp_data", {56'b0, bus.rsp_data}, {56'b0, exp_q.pop_front()});
                end
                rsp_cnt <= rsp_cnt + 1;
                rsp_cyc <= cyc;
            end
            if (bus.cmd_ready) chk("ready_implies_idle", {62'b0, bus.busy, bus.rsp_valid}, 64'd0);
        end
    end

    task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic [7:0] exp,
                          input bit poke, output longint lat);
        int     n;
        int     rc;
        longint acc;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: cmd_ready 0 want 1");
        end
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.cmd_data  = d;
        exp_q.push_back(exp);
        rc  = rsp_cnt;
        acc = cyc;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'($urandom);
        chk("busy_after_accept", {63'b0, bus.busy}, 64'd1);
        chk("ready_after_accept", {63'b0, bus.cmd_ready}, 64'd0);
        if (poke) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                bus.cmd_valid = 1'b1;
                bus.cmd       = 2'd1;
                chk("ready_while_busy", {63'b0, bus.cmd_ready}, 64'd0);
            end
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
        n = 0;
        while (rsp_cnt == rc && n < 1100 * T) begin
            @(negedge clk);
            n++;
        end
        if (rsp_cnt == rc) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", 1100 * T);
        end
        lat = rsp_cyc - acc;
    endtask

    task automatic run_op(input logic [1:0] c, input logic [7:0] d, input int mode, input bit poke);
        logic [7:0] exp;
        logic [7:0] wire_byte;
        longint     lat;
        int         n_us;
        pw_q.delete();
        st_q.delete();
        dev_mode = mode;
        case (c)
            2'd0:    exp = (mode == 1) ? 8'h01 : (mode == 2) ? 8'h03 : 8'h00;
            2'd2:    exp = d;
            default: exp = 8'h00;
        endcase
        if (c == 2'd2) begin
            rd_byte = d;
            rd_idx  = 0;
            rd_mode = 1'b1;
        end
        if (c == 2'd0 && mode == 2) dev_low = 1'b1;
        repeat ($urandom_range(0, T + 3)) @(posedge clk);
        do_cmd(c, (c == 2'd2) ? 8'($urandom) : d, exp, poke, lat);
        if (c == 2'd0 && mode == 2) dev_low = 1'b0;
        rd_mode = 1'b0;
        repeat (2) @(posedge clk);
        case (c)
            2'd0: begin
                chk("rst_pulse_count", pw_q.size(), 1);
                if (pw_q.size() >= 1) chk_rng("rst_low_width", pw_q[0], 479 * T, 481 * T);
                chk_rng("rst_latency", lat, 958 * T, 962 * T);
            end
            2'd1, 2'd2: begin
                chk("slot_count", pw_q.size(), 8);
                wire_byte = 8'h00;
                for (int i = 0; i < 8 && i < pw_q.size(); i++) begin
                    n_us = (c == 2'd1 && !d[i]) ? 60 : 6;
                    chk_rng("slot_low_width", pw_q[i], n_us * T - T, n_us * T + T);
                    wire_byte[i] = (pw_q[i] < 30 * T);
                    if (i > 0) chk_rng("slot_spacing", st_q[i] - st_q[i-1], 69 * T, 71 * T);
                end
                if (c == 2'd1) chk("wire_byte", {56'b0, wire_byte}, {56'b0, d});
                chk_rng("byte_latency", lat, 558 * T, 562 * T);
            end
            default: begin
                chk("nop_latency", lat, 2);
                chk("nop_pulse_count", pw_q.size(), 0);
            end
        endcase
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int rc;
        logic pad_before;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'd3;
        bus.cmd_data  = 8'h00;

        #12;
        chk("rst_pad_drive_n", {63'b0, pad_drive_n}, 64'd1);
        chk("rst_cmd_ready", {63'b0, bus.cmd_ready}, 64'd0);
        chk("rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_data", {56'b0, bus.rsp_data}, 64'd0);
        chk("rst_busy", {63'b0, bus.busy}, 64'd0);
        @(negedge clk);
        nReset = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_first_edge", {63'b0, bus.cmd_ready}, 64'd1);

        run_op(2'd0, 8'h00, 1, 1'b0);
        run_op(2'd0, 8'h00, 0, 1'b0);
        run_op(2'd0, 8'h00, 2, 1'b0);
        run_op(2'd1, 8'h33, 0, 1'b0);
        run_op(2'd2, 8'hA5, 0, 1'b0);
        run_op(2'd2, 8'($urandom), 0, 1'b1);
        run_op(2'd3, 8'($urandom), 0, 1'b0);

        // Abandon a write in its first (written-0) low phase.
        pw_q.delete();
        st_q.delete();
        dev_mode = 0;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd       = 2'd1;
        bus.cmd_data  = 8'h00;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (pad_drive_n && n < 100 * T) begin
            @(posedge clk);
            n++;
        end
        repeat (5 * T) @(posedge clk);
        #3;
        pad_before = pad_drive_n;
        rc = rsp_cnt;
        nReset = 1'b0;
        #1;
        chk("abort_slot_low_seen", {63'b0, pad_before}, 64'd0);
        chk("abort_pad_released", {63'b0, pad_drive_n}, 64'd1);
        chk("abort_busy", {63'b0, bus.busy}, 64'd0);
        chk("abort_cmd_ready", {63'b0, bus.cmd_ready}, 64'd0);
        chk("abort_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready_after", {63'b0, bus.cmd_ready}, 64'd1);
        repeat (100 * T) @(posedge clk);
        chk("abort_no_rsp", rsp_cnt, rc);
        run_op(2'd0, 8'h00, 1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_op(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 2), 1'b0);
        end

        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/onewire_master.md
Name: onewire_master

Overview:
- Byte-level 1-Wire bus master for the DS2401/DS2433 security and ID chips on the cartridge and digital I/O board.
- Sits directly upstream of the I/O pad primitives:
  - its `pad_drive_n` output feeds the T input of an OBUFT whose I is tied to GND, forming an open-drain driver;
  - its `pad_in` input comes from the IBUF of the same IOPAD.
- The host-bus register block issues reset, write-byte and read-byte commands through a valid/ready handshake and collects results from a one-cycle response strobe.

Parameters:
- TICK_DIV, 29: clock cycles per 1 µs tick (29.4912 MHz board clock, truncated).
- RESET_LOW_US, 480: duration the bus is held low for a reset pulse.
- PRESENCE_US, 70: delay from reset release to the presence sample.
- RESET_TOTAL_US, 480: delay from reset release to command completion.
- SLOT_US, 70: total bit-slot length, including recovery time.
- WRITE0_LOW_US, 60: low time for a written 0.
- SHORT_LOW_US, 6: low time for a written 1 and for a read slot.
- SAMPLE_US, 15: read sample point, measured from slot start.

Ports:
- clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd  in  2  command code: 0 = BUS_RESET, 1 = WRITE_BYTE, 2 = READ_BYTE, 3 = NOP.
- cmd_data  in  8  byte to write; sampled only on accept.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_data  out  8  read byte, or reset status (bit0 = presence, bit1 = short); 0 for WRITE_BYTE and NOP.
- busy  out  1  a command is in progress.
- pad_drive_n  out  1  0 = pull bus low; 1 = release bus (tri-state).
- pad_in  in  1  raw bus level, asynchronous.

Behaviour:
- **Reset values:** while nReset = 0, all outputs take these values asynchronously:
  - pad_drive_n = 1 (bus released immediately, even mid-slot);
  - cmd_ready = 0, rsp_valid = 0, rsp_data = 0, busy = 0.
  - After reset is released, cmd_ready rises on the first clk edge.
- **Input synchronisation:** pad_in passes through a two-flop synchroniser, which reset sets to 1. All samples use the synchronised value, i.e. the pad level from 2 cycles earlier.
- **Timebase:**
  - The prescaler counts 0..TICK_DIV-1 and emits `us_tick` on wrap.
  - A 10-bit µs counter clears on every state entry and increments on `us_tick`.
  - Every duration is "counter reaches N", so the actual time is N µs minus at most one tick of phase error.
  - The prescaler is not reset per state.
- **Handshake:**
  - A command is accepted on a cycle where cmd_valid and cmd_ready are both 1.
  - cmd_ready = (state == IDLE) and not rsp_valid.
  - cmd and cmd_data are latched on accept. cmd_valid while busy is ignored; no queueing.
- **States:** IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_HIGH, DONE.
- **IDLE:**
  - BUS_RESET goes to RST_LOW.
  - WRITE_BYTE and READ_BYTE load the shift register (cmd_data, or 0xFF for a read), set bit_cnt = 0, and go to SLOT_LOW.
  - NOP goes to DONE.
- **RST_LOW:** pad_drive_n = 0 for RESET_LOW_US, then RST_WAIT.
- **RST_WAIT:** bus released.
  - At PRESENCE_US: presence = ~pad_sync.
  - At RESET_TOTAL_US: short = ~pad_sync, then go to DONE.
- **SLOT_LOW:** pad_drive_n = 0.
  - Lasts WRITE0_LOW_US if the current bit is a written 0; otherwise SHORT_LOW_US.
  - Then go to SLOT_HIGH.
- **SLOT_HIGH:** bus released.
  - Timing in this state is measured as total time since slot start.
  - For READ_BYTE, pad_sync is captured at SAMPLE_US.
  - At SLOT_US the shift register shifts right, with the captured bit (read) or don't-care (write) entering at bit 7.
  - bit_cnt increments. If bit_cnt was 7, go to DONE; otherwise go to SLOT_LOW.
- **Bit order:** LSB first on the wire for both writes and reads.
- **DONE:**
  - rsp_valid = 1 for exactly one cycle, and rsp_data is updated in the same cycle.
  - Then IDLE.
  - rsp_data holds its value until the next DONE.
- **busy:** 1 from the accept cycle through the DONE cycle.
- **Timing summary:**
  - BUS_RESET latency ≈ 960 µs.
  - Byte latency ≈ 8 × 70 µs = 560 µs.
  - NOP latency = 2 cycles from accept to rsp_valid.
- **Reset mid-operation:** the command is abandoned with no rsp_valid. The bus is released within the reset assertion itself, not on a clock edge.

Decomposition:
- **onewire_pkg:** command codes, state encoding and default timing constants.
- **onewire_timebase sub-module:**
  - holds the prescaler and µs counter;
  - inputs: clk, nReset, clear;
  - outputs: us_tick, us_count[9:0].
- All remaining logic lives in onewire_master.

Test Plan:
1. **Bus reset with device present:** cmd = 0; bench model pulls the bus low from 15 µs to 135 µs after release.
   - pad_drive_n low for 480 ±1 µs.
   - rsp_valid about 960 µs after accept, with rsp_data = 0x01.
2. **Bus reset with no device, then with a shorted bus:**
   - Bus stays high → rsp_data = 0x00.
   - Bus held low permanently → rsp_data = 0x03.
3. **WRITE_BYTE 0x33:** low pulses observed in slot order 6, 6, 60, 60, 6, 6, 60, 60 µs.
   - Slot starts spaced 70 µs apart.
   - rsp_data = 0x00.
4. **READ_BYTE:** model drives bit pattern 0xA5, LSB first, holding the bus low until 30 µs for 0-bits.
   - rsp_data = 0xA5.
   - Each slot's low pulse is 6 µs.
5. **Command during busy, then NOP:**
   - A second cmd_valid during a read is ignored and cmd_ready stays 0.
   - A NOP after completion gives rsp_valid 2 cycles after accept with rsp_data = 0x00.
6. **Reset mid-operation:** nReset asserted during SLOT_LOW of a write.
   - pad_drive_n = 1 with no clock edge.
   - No rsp_valid.
   - After release, cmd_ready = 1 and a subsequent BUS_RESET completes normally.
